// File: rtl/axi_pmu_param.sv
// AXI4-Lite performance monitoring unit: N_COUNTERS 32-bit event counters with runtime event select,
// sticky overflow status, maskable overflow interrupt and optional freeze-on-overflow.
module axi_pmu_param #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int N_EVENTS           = 32,
    parameter int N_COUNTERS         = 8
) (
    input  logic                              S_AXI_ACLK_i,
    input  logic                              S_AXI_ARESET_i,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR_i,
    input  logic                              S_AXI_AWVALID_i,
    output logic                              S_AXI_AWREADY_o,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA_i,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB_i,
    input  logic                              S_AXI_WVALID_i,
    output logic                              S_AXI_WREADY_o,
    output logic [1:0]                        S_AXI_BRESP_o,
    output logic                              S_AXI_BVALID_o,
    input  logic                              S_AXI_BREADY_i,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR_i,
    input  logic                              S_AXI_ARVALID_i,
    output logic                              S_AXI_ARREADY_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA_o,
    output logic [1:0]                        S_AXI_RRESP_o,
    output logic                              S_AXI_RVALID_o,
    input  logic                              S_AXI_RREADY_i,
    input  logic [N_EVENTS-1:0]               events_i,
    output logic                              int_overflow_o,
    output logic [N_COUNTERS-1:0]             ovf_status_o
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int SW     = DW / 8;
    localparam int SEL_W  = $clog2(N_EVENTS);
    localparam int EV_PAD = 1 << SEL_W;

    typedef struct packed {
        logic       ok;
        logic       ctrl;
        logic       ovf;
        logic       mask;
        logic       sel;
        logic       cnt;
        logic [3:0] idx;
    } dec_t;

    function automatic dec_t decode(input logic [AW-1:0] addr);
        dec_t       d;
        logic [7:0] off;
        d     = '0;
        off   = addr[7:0];
        d.idx = off[5:2];
        if (((addr >> 8) == '0) && (off[1:0] == 2'b00)) begin
            case (off[7:6])
                2'b00: begin
                    d.ctrl = (off[5:2] == 4'd0);
                    d.ovf  = (off[5:2] == 4'd1);
                    d.mask = (off[5:2] == 4'd2);
                end
                2'b01:   d.sel = (32'(off[5:2]) < N_COUNTERS);
                2'b10:   d.cnt = (32'(off[5:2]) < N_COUNTERS);
                default: ;
            endcase
        end
        d.ok = d.ctrl | d.ovf | d.mask | d.sel | d.cnt;
        return d;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] bits,
                                            input logic [DW-1:0] lanes);
        return (old & ~lanes) | bits;
    endfunction

    logic                  aw_rdy, ar_rdy, b_vld, r_vld;
    logic [1:0]            b_resp, r_resp;
    logic [DW-1:0]         r_data;
    logic                  en, freeze_en, irq;
    logic [N_COUNTERS-1:0] ovf, mask, ovf_nxt, inc, wr_cnt_hit;
    logic [SEL_W-1:0]      sel [N_COUNTERS];
    logic [DW-1:0]         cnt [N_COUNTERS];
    logic [N_EVENTS-1:0]   ev_q;
    logic [EV_PAD-1:0]     ev_pad;
    dec_t                  wr_dec, rd_dec;
    logic                  wr_fire, rd_fire, clr, frozen;
    logic [DW-1:0]         lanes, wbits, ctrl_cur, ctrl_new, mask_new, rd_val;

    assign wr_dec   = decode(S_AXI_AWADDR_i);
    assign rd_dec   = decode(S_AXI_ARADDR_i);
    assign wr_fire  = aw_rdy & S_AXI_AWVALID_i & S_AXI_WVALID_i;
    assign rd_fire  = ar_rdy & S_AXI_ARVALID_i;
    assign wbits    = S_AXI_WDATA_i & lanes;
    assign clr      = wr_fire & wr_dec.ctrl & S_AXI_WSTRB_i[0] & S_AXI_WDATA_i[1];
    assign frozen   = freeze_en & (|(ovf & mask));
    // Out-of-range selects land on zero padding, so such counters never count.
    assign ev_pad   = EV_PAD'(ev_q);
    assign ctrl_cur = DW'({freeze_en, 1'b0, en});
    assign ctrl_new = merge(ctrl_cur, wbits, lanes);
    assign mask_new = merge(DW'(mask), wbits, lanes);

    always_comb begin
        lanes = '0;
        for (int b = 0; b < SW; b++) lanes[b*8 +: 8] = {8{S_AXI_WSTRB_i[b]}};
    end

    always_comb begin
        ovf_nxt    = ovf;
        inc        = '0;
        wr_cnt_hit = '0;
        if (wr_fire && wr_dec.ovf) ovf_nxt = ovf & ~wbits[N_COUNTERS-1:0];
        // A wrap on this edge sets the bit even if the same write clears it.
        for (int i = 0; i < N_COUNTERS; i++) begin
            wr_cnt_hit[i] = wr_fire & wr_dec.cnt & (wr_dec.idx == 4'(i));
            inc[i]        = en & ~frozen & ev_pad[sel[i]];
            if (inc[i] && !wr_cnt_hit[i] && (cnt[i] == '1)) ovf_nxt[i] = 1'b1;
        end
        if (clr) ovf_nxt = '0;
    end

    always_comb begin
        rd_val = '0;
        if (rd_dec.ctrl) rd_val = ctrl_cur;
        if (rd_dec.ovf)  rd_val[N_COUNTERS-1:0] = ovf;
        if (rd_dec.mask) rd_val[N_COUNTERS-1:0] = mask;
        for (int i = 0; i < N_COUNTERS; i++) begin
            if (rd_dec.sel && (rd_dec.idx == 4'(i))) rd_val[SEL_W-1:0] = sel[i];
            if (rd_dec.cnt && (rd_dec.idx == 4'(i))) rd_val = cnt[i];
        end
    end

    always_ff @(posedge S_AXI_ACLK_i) begin
        if (S_AXI_ARESET_i) begin
            aw_rdy    <= 1'b0;
            ar_rdy    <= 1'b0;
            b_vld     <= 1'b0;
            r_vld     <= 1'b0;
            b_resp    <= 2'b00;
            r_resp    <= 2'b00;
            r_data    <= '0;
            en        <= 1'b0;
            freeze_en <= 1'b0;
            irq       <= 1'b0;
            ovf       <= '0;
            mask      <= '0;
            ev_q      <= '0;
            for (int i = 0; i < N_COUNTERS; i++) begin
                sel[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            aw_rdy <= ~aw_rdy & S_AXI_AWVALID_i & S_AXI_WVALID_i & ~b_vld;
            if (wr_fire) begin
                b_vld  <= 1'b1;
                b_resp <= wr_dec.ok ? 2'b00 : 2'b10;
            end else if (b_vld && S_AXI_BREADY_i) begin
                b_vld <= 1'b0;
            end

            ar_rdy <= ~ar_rdy & S_AXI_ARVALID_i & ~r_vld;
            if (rd_fire) begin
                r_vld  <= 1'b1;
                r_data <= rd_val;
                r_resp <= rd_dec.ok ? 2'b00 : 2'b10;
            end else if (r_vld && S_AXI_RREADY_i) begin
                r_vld <= 1'b0;
            end

            ev_q <= events_i;
            irq  <= |(ovf & mask);
            ovf  <= ovf_nxt;
            if (wr_fire && wr_dec.ctrl) begin
                en        <= ctrl_new[0];
                freeze_en <= ctrl_new[2];
            end
            if (wr_fire && wr_dec.mask) mask <= mask_new[N_COUNTERS-1:0];

            for (int i = 0; i < N_COUNTERS; i++) begin
                if (wr_fire && wr_dec.sel && (wr_dec.idx == 4'(i)))
                    sel[i] <= SEL_W'(merge(DW'(sel[i]), wbits, lanes));
                if (clr)
                    cnt[i] <= '0;
                else if (wr_cnt_hit[i])
                    cnt[i] <= merge(cnt[i], wbits, lanes);
                else if (inc[i])
                    cnt[i] <= cnt[i] + DW'(1);
            end
        end
    end

    assign S_AXI_AWREADY_o = aw_rdy;
    assign S_AXI_WREADY_o  = aw_rdy;
    assign S_AXI_BVALID_o  = b_vld;
    assign S_AXI_BRESP_o   = b_resp;
    assign S_AXI_ARREADY_o = ar_rdy;
    assign S_AXI_RVALID_o  = r_vld;
    assign S_AXI_RDATA_o   = r_data;
    assign S_AXI_RRESP_o   = r_resp;
    assign int_overflow_o  = irq;
    assign ovf_status_o    = ovf;

endmodule

// File: tb/tb_axi_pmu_param.sv
// Bench for axi_pmu_param: AXI-Lite master tasks, expected read/write responses queued at issue
// and compared when the DUT responds.
module tb_axi_pmu_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [31:0] events;
    logic        irq;
    logic [7:0]  ovf_st;

    logic [33:0] rd_q[$];
    logic [1:0]  wr_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    axi_pmu_param dut (
        .S_AXI_ACLK_i    (clk),
        .S_AXI_ARESET_i  (rst),
        .S_AXI_AWADDR_i  (awaddr),
        .S_AXI_AWVALID_i (awvalid),
        .S_AXI_AWREADY_o (awready),
        .S_AXI_WDATA_i   (wdata),
        .S_AXI_WSTRB_i   (wstrb),
        .S_AXI_WVALID_i  (wvalid),
        .S_AXI_WREADY_o  (wready),
        .S_AXI_BRESP_o   (bresp),
        .S_AXI_BVALID_o  (bvalid),
        .S_AXI_BREADY_i  (bready),
        .S_AXI_ARADDR_i  (araddr),
        .S_AXI_ARVALID_i (arvalid),
        .S_AXI_ARREADY_o (arready),
        .S_AXI_RDATA_o   (rdata),
        .S_AXI_RRESP_o   (rresp),
        .S_AXI_RVALID_o  (rvalid),
        .S_AXI_RREADY_i  (rready),
        .events_i        (events),
        .int_overflow_o  (irq),
        .ovf_status_o    (ovf_st)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_hi(input string tag, ref logic sig);
        int k = 0;
        @(negedge clk);
        while (!sig && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!sig) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic axi_wr(input string tag, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] eresp, input bit drop_ev);
        logic [1:0] e;
        wr_q.push_back(eresp);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        wait_hi({tag, "_awready"}, awready);
        if (drop_ev) events = '0;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_hi({tag, "_bvalid"}, bvalid);
        e = wr_q.pop_front();
        chk({tag, "_bresp"}, 32'(bresp), 32'(e));
        @(posedge clk); #1;
    endtask

    task automatic axi_rd(input string tag, input logic [7:0] a, input logic [31:0] exp,
                          input logic [1:0] eresp);
        logic [33:0] e;
        rd_q.push_back({eresp, exp});
        araddr = a; arvalid = 1'b1;
        wait_hi({tag, "_arready"}, arready);
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_hi({tag, "_rvalid"}, rvalid);
        e = rd_q.pop_front();
        chk({tag, "_rdata"}, rdata, e[31:0]);
        chk({tag, "_rresp"}, 32'(rresp), 32'(e[33:32]));
        @(posedge clk); #1;
    endtask

    task automatic pulse_ev(input logic [31:0] m, input int n);
        @(negedge clk);
        events = m;
        repeat (n) @(negedge clk);
        events = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; wdata = '0; wstrb = '0;
        bready = 1'b1; arvalid = 0; rready = 1'b1; events = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'({awready, wready, arready}), 32'd0);
        chk("rst_valid", 32'({bvalid, rvalid}), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        axi_rd("rst_ctrl", 8'h00, 32'd0, 2'b00);
        axi_rd("rst_cnt0", 8'h80, 32'd0, 2'b00);
        axi_rd("rst_ovf", 8'h04, 32'd0, 2'b00);

        // basic counting, shared select, unselected event
        axi_wr("sel0", 8'h40, 32'd5, 4'hF, 2'b00, 0);
        axi_wr("sel1", 8'h44, 32'd5, 4'hF, 2'b00, 0);
        axi_wr("en", 8'h00, 32'd1, 4'hF, 2'b00, 0);
        pulse_ev(32'h20, 10);
        pulse_ev(32'h10, 5);
        axi_rd("cnt0_10", 8'h80, 32'd10, 2'b00);
        axi_rd("cnt1_10", 8'h84, 32'd10, 2'b00);
        axi_rd("sel0_rb", 8'h40, 32'd5, 2'b00);

        // wrap sets sticky status and interrupt
        axi_wr("cnt2", 8'h88, 32'hFFFF_FFFE, 4'hF, 2'b00, 0);
        axi_wr("sel2", 8'h48, 32'd3, 4'hF, 2'b00, 0);
        axi_wr("mask", 8'h08, 32'd4, 4'hF, 2'b00, 0);
        pulse_ev(32'h08, 3);
        axi_rd("cnt2_wrap", 8'h88, 32'd1, 2'b00);
        axi_rd("ovf_set", 8'h04, 32'd4, 2'b00);
        chk("irq_set", 32'(irq), 32'd1);
        chk("ovf_port", 32'(ovf_st), 32'd4);
        axi_wr("w1c", 8'h04, 32'd4, 4'hF, 2'b00, 0);
        @(negedge clk);
        chk("irq_clr", 32'(irq), 32'd0);
        axi_rd("ovf_clr", 8'h04, 32'd0, 2'b00);

        // freeze on overflow, resume after clear
        axi_wr("cnt2_b", 8'h88, 32'hFFFF_FFFE, 4'hF, 2'b00, 0);
        axi_wr("frz", 8'h00, 32'd5, 4'hF, 2'b00, 0);
        pulse_ev(32'h28, 6);
        axi_rd("frz_cnt2", 8'h88, 32'd0, 2'b00);
        axi_rd("frz_cnt0", 8'h80, 32'd12, 2'b00);
        axi_rd("frz_cnt1", 8'h84, 32'd12, 2'b00);
        axi_rd("frz_ovf", 8'h04, 32'd4, 2'b00);
        axi_wr("frz_w1c", 8'h04, 32'd4, 4'hF, 2'b00, 0);
        pulse_ev(32'h20, 3);
        axi_rd("resume_cnt0", 8'h80, 32'd15, 2'b00);

        // unmapped accesses
        axi_rd("rd_f0", 8'hF0, 32'd0, 2'b10);
        axi_rd("rd_cnt8", 8'hA0, 32'd0, 2'b10);
        axi_rd("rd_sel8", 8'h60, 32'd0, 2'b10);
        axi_wr("wr_cnt8", 8'hA0, 32'hFFFF_FFFF, 4'hF, 2'b10, 0);
        axi_wr("wr_f0", 8'hF0, 32'hFFFF_FFFF, 4'hF, 2'b10, 0);
        axi_rd("ctrl_keep", 8'h00, 32'd5, 2'b00);
        axi_rd("cnt0_keep", 8'h80, 32'd15, 2'b00);
        axi_rd("mask_keep", 8'h08, 32'd4, 2'b00);

        // back-pressure on B with a second write pending
        bready = 1'b0;
        awaddr = 8'h80; wdata = 32'h1111_1111; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        wait_hi("bp_awready", awready);
        @(posedge clk); #1;
        wdata = 32'h2222_2222;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_bvalid_%0d", c), 32'(bvalid), 32'd1);
            chk($sformatf("bp_awready_%0d", c), 32'(awready), 32'd0);
        end
        bready = 1'b1;
        wait_hi("bp_awready2", awready);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        wait_hi("bp_bvalid2", bvalid);
        chk("bp_bresp2", 32'(bresp), 32'd0);
        @(posedge clk); #1;
        axi_rd("bp_cnt0", 8'h80, 32'h2222_2222, 2'b00);

        // byte-lane strobe and write-beats-increment
        axi_wr("strb", 8'h80, 32'hAABB_CCDD, 4'b0001, 2'b00, 0);
        axi_rd("strb_cnt0", 8'h80, 32'h2222_22DD, 2'b00);
        @(negedge clk);
        events = 32'h20;
        repeat (3) @(negedge clk);
        axi_wr("wr_vs_inc", 8'h80, 32'h0000_0100, 4'hF, 2'b00, 1);
        repeat (3) @(negedge clk);
        axi_rd("wr_vs_inc_cnt0", 8'h80, 32'h0000_0100, 2'b00);

        // CLR zeroes counters, keeps control bits
        axi_wr("clr", 8'h00, 32'd7, 4'hF, 2'b00, 0);
        axi_rd("clr_cnt0", 8'h80, 32'd0, 2'b00);
        axi_rd("clr_ctrl", 8'h00, 32'd5, 2'b00);
        axi_rd("clr_sel0", 8'h40, 32'd5, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
